// File: rtl/clk_period_meas.sv
// Measures the period of a slow asynchronous signal in system-clock cycles.
// One result per rising edge after the first; saturates at 2^CNT_W-1 with overflow.
module clk_period_meas #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clockin,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sig_s;
  logic                   sig_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;

  // sync[0] is the metastability-exposed flop; sig_s is the settled copy
  always_ff @(posedge clockin or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      sig_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], sig_in};
      sig_d <= sig_s;
    end
  end

  assign sig_s = sync[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;

  always_ff @(posedge clockin or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      period   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        // dropping enable discards any edge seen this cycle and forces a fresh ARM
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
            busy  <= 1'b1;
          end
          ARM: begin
            busy <= 1'b1;
            if (rise) begin
              state <= MEASURE;
              cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          MEASURE: begin
            busy <= 1'b1;
            if (rise) begin
              period   <= cnt;
              overflow <= (cnt == CNT_MAX);
              valid    <= 1'b1;
              cnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
